// File: rtl/ctrl_fsm.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, writeback.
// Drives IR/PC/ALU/regfile/dmem strobes and handshakes with imem/dmem via req/ack.
//
// state  | meaning
// FETCH  | request instruction; on ack load IR and advance PC by 4
// DECODE | latch opcode, pick next state (trap/halt/nop/exec)
// EXEC   | drive ALU controls; resolve branches and jumps
// MEM    | data memory access, held until ack
// WB     | one-cycle register file write
// HALT   | terminal after HALT opcode, only reset exits
// TRAP   | terminal after illegal opcode, only reset exits
module ctrl_fsm (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] opcode_i,
  input  logic       zero_i,
  output logic       imem_req_o,
  input  logic       imem_ack_i,
  output logic       dmem_req_o,
  output logic       dmem_we_o,
  input  logic       dmem_ack_i,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [1:0] pc_src_o,
  output logic [2:0] alu_op_o,
  output logic       alu_src_b_o,
  output logic       rf_we_o,
  output logic       wb_sel_o,
  output logic       halted_o,
  output logic       illegal_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hD;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_REL = 2'd1;
  localparam logic [1:0] PC_ABS = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_opcode;
  logic [2:0] w_alu_op;
  logic       w_alu_src_b;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_FETCH;
      r_opcode <= OP_NOP;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= opcode_i;
    end
  end

  // ALU controls depend only on the latched opcode, so EXEC, MEM and WB share them.
  always_comb begin
    w_alu_op    = ALU_ADD;
    w_alu_src_b = 1'b0;
    case (r_opcode)
      4'h1: w_alu_op = ALU_ADD;
      4'h2: w_alu_op = ALU_SUB;
      4'h3: w_alu_op = ALU_AND;
      4'h4: w_alu_op = ALU_OR;
      4'h5: w_alu_op = ALU_XOR;
      4'h6: w_alu_op = ALU_SLT;
      4'h7, OP_LD, OP_ST: w_alu_src_b = 1'b1;
      OP_BEQ, OP_BNE: w_alu_op = ALU_SUB;
      default: ;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    imem_req_o  = 1'b0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_src_o    = PC_SEQ;
    alu_op_o    = ALU_ADD;
    alu_src_b_o = 1'b0;
    rf_we_o     = 1'b0;
    wb_sel_o    = 1'b0;
    halted_o    = 1'b0;
    illegal_o   = 1'b0;
    state_o     = r_state;
    if (rst_i) begin
      // Reset cycle: every output quiet, including the fetch request.
      w_next  = S_FETCH;
      state_o = 3'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          imem_req_o = 1'b1;
          if (imem_ack_i) begin
            ir_we_o  = 1'b1;
            pc_we_o  = 1'b1;
            pc_src_o = PC_SEQ;
            w_next   = S_DECODE;
          end
        end
        S_DECODE: begin
          case (opcode_i)
            4'hE, 4'hF: w_next = S_TRAP;
            OP_HALT:    w_next = S_HALT;
            OP_NOP:     w_next = S_FETCH;
            default:    w_next = S_EXEC;
          endcase
        end
        S_EXEC: begin
          alu_op_o    = w_alu_op;
          alu_src_b_o = w_alu_src_b;
          case (r_opcode)
            OP_LD, OP_ST: w_next = S_MEM;
            OP_BEQ: begin
              pc_src_o = PC_REL;
              pc_we_o  = zero_i;
              w_next   = S_FETCH;
            end
            OP_BNE: begin
              pc_src_o = PC_REL;
              pc_we_o  = !zero_i;
              w_next   = S_FETCH;
            end
            OP_JMP: begin
              pc_src_o = PC_ABS;
              pc_we_o  = 1'b1;
              w_next   = S_FETCH;
            end
            default: w_next = S_WB;
          endcase
        end
        S_MEM: begin
          dmem_req_o  = 1'b1;
          dmem_we_o   = (r_opcode == OP_ST);
          alu_op_o    = w_alu_op;
          alu_src_b_o = w_alu_src_b;
          if (dmem_ack_i) w_next = (r_opcode == OP_ST) ? S_FETCH : S_WB;
        end
        S_WB: begin
          rf_we_o     = 1'b1;
          wb_sel_o    = (r_opcode == OP_LD);
          alu_op_o    = w_alu_op;
          alu_src_b_o = w_alu_src_b;
          w_next      = S_FETCH;
        end
        S_HALT:  halted_o  = 1'b1;
        S_TRAP:  illegal_o = 1'b1;
        default: w_next    = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: an instruction-level model expands each
// opcode into its expected per-cycle output trace, with random noise on ignored inputs.
module tb_ctrl_fsm;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] opcode_i = 4'h0;
  logic       zero_i = 1'b0;
  logic       imem_req_o;
  logic       imem_ack_i = 1'b0;
  logic       dmem_req_o;
  logic       dmem_we_o;
  logic       dmem_ack_i = 1'b0;
  logic       ir_we_o;
  logic       pc_we_o;
  logic [1:0] pc_src_o;
  logic [2:0] alu_op_o;
  logic       alu_src_b_o;
  logic       rf_we_o;
  logic       wb_sel_o;
  logic       halted_o;
  logic       illegal_o;
  logic [2:0] state_o;

  ctrl_fsm dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i),
    .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
    .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .pc_src_o(pc_src_o),
    .alu_op_o(alu_op_o), .alu_src_b_o(alu_src_b_o), .rf_we_o(rf_we_o),
    .wb_sel_o(wb_sel_o), .halted_o(halted_o), .illegal_o(illegal_o),
    .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       alu_src_b;
    logic       rf_we;
    logic       wb_sel;
    logic       halted;
    logic       illegal;
    logic [2:0] state;
  } outs_t;

  outs_t w_obs;
  assign w_obs = {imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, pc_src_o,
                  alu_op_o, alu_src_b_o, rf_we_o, wb_sel_o, halted_o, illegal_o, state_o};

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  // Opcode-to-ALU map as listed in the instruction table.
  function automatic logic [2:0] alu_of(input logic [3:0] op);
    case (op)
      4'h2, 4'hA, 4'hB: return 3'd1;
      4'h3: return 3'd2;
      4'h4: return 3'd3;
      4'h5: return 3'd4;
      4'h6: return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic srcb_of(input logic [3:0] op);
    return (op == 4'h7 || op == 4'h8 || op == 4'h9);
  endfunction

  task automatic check(input string tag, input outs_t e);
    n_cmp++;
    assert (w_obs === e) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, w_obs, e);
    end
  endtask

  task automatic step(input logic rst, input logic ia, input logic da, input logic [3:0] op,
                      input logic z, input outs_t e, input string tag);
    rst_i = rst; imem_ack_i = ia; dmem_ack_i = da; opcode_i = op; zero_i = z;
    #2;
    check(tag, e);
    @(posedge clk_i);
    #1;
  endtask

  // Expands one instruction into its cycle trace. Returns the number of cycles
  // taken so callers can also check total latency.
  task automatic run_instr(input logic [3:0] op, input logic z, input int iw, input int dw,
                           output int cycles);
    outs_t e;
    cycles = 0;
    for (int i = 0; i < iw; i++) begin
      e = '0; e.imem_req = 1'b1;
      step(1'b0, 1'b0, rb(), rop(), rb(), e, "fetch_wait"); cycles++;
    end
    e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    step(1'b0, 1'b1, rb(), rop(), rb(), e, "fetch_ack"); cycles++;
    e = '0; e.state = 3'd1;
    step(1'b0, rb(), rb(), op, rb(), e, "decode"); cycles++;
    if (op == 4'h0 || op >= 4'hD) return;
    e = '0; e.state = 3'd2; e.alu_op = alu_of(op); e.alu_src_b = srcb_of(op);
    if (op == 4'hA) begin e.pc_src = 2'd1; e.pc_we = z;  end
    if (op == 4'hB) begin e.pc_src = 2'd1; e.pc_we = !z; end
    if (op == 4'hC) begin e.pc_src = 2'd2; e.pc_we = 1'b1; e.alu_op = 3'd0; end
    step(1'b0, rb(), rb(), rop(), z, e, "exec"); cycles++;
    if (op >= 4'hA) return;
    if (op == 4'h8 || op == 4'h9) begin
      for (int i = 0; i <= dw; i++) begin
        e = '0; e.state = 3'd3; e.dmem_req = 1'b1; e.dmem_we = (op == 4'h9);
        e.alu_op = 3'd0; e.alu_src_b = 1'b1;
        step(1'b0, rb(), (i == dw), rop(), rb(), e, "mem"); cycles++;
      end
      if (op == 4'h9) return;
    end
    e = '0; e.state = 3'd4; e.rf_we = 1'b1; e.wb_sel = (op == 4'h8);
    e.alu_op = alu_of(op); e.alu_src_b = srcb_of(op);
    step(1'b0, rb(), rb(), rop(), rb(), e, "wb"); cycles++;
  endtask

  function automatic int latency(input logic [3:0] op, input int iw, input int dw);
    int base;
    case (op)
      4'h0: base = 2;
      4'hA, 4'hB, 4'hC: base = 3;
      4'h8: base = 5 + dw;
      4'h9: base = 4 + dw;
      default: base = 4;
    endcase
    return base + iw;
  endfunction

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, rb(), rb(), rop(), rb(), '0, "reset_quiet");
  endtask

  task automatic lat_check(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  initial begin
    outs_t e;
    int cyc;
    logic [3:0] op;
    int iw, dw;
    logic z;

    #1;
    do_reset(2);

    // Reset then ADD with no waits: 0,1,2,4,0.
    run_instr(4'h1, 1'b0, 0, 0, cyc);
    lat_check("lat_add", cyc, 4);
    // LD with dmem ack delayed 3 cycles.
    run_instr(4'h8, 1'b0, 0, 3, cyc);
    lat_check("lat_ld_wait3", cyc, 8);
    run_instr(4'hA, 1'b1, 0, 0, cyc);
    lat_check("lat_beq", cyc, 3);
    run_instr(4'hB, 1'b1, 0, 0, cyc);
    run_instr(4'h0, 1'b0, 0, 0, cyc);
    lat_check("lat_nop", cyc, 2);
    run_instr(4'h9, 1'b0, 1, 0, cyc);
    lat_check("lat_st_iwait1", cyc, 5);

    // Random legal instruction stream.
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 12));
      iw = $urandom_range(0, 2);
      dw = $urandom_range(0, 2);
      z  = rb();
      run_instr(op, z, iw, dw, cyc);
      lat_check("lat_rand", cyc, latency(op, iw, dw));
    end

    // Reset during fetch while ack pulses: nothing fires, fetch restarts.
    step(1'b1, 1'b1, rb(), rop(), rb(), '0, "rst_mid_fetch");
    e = '0; e.imem_req = 1'b1;
    step(1'b0, 1'b0, 1'b0, rop(), rb(), e, "fetch_restart");

    // Reset during a pending load with dmem ack in the same cycle.
    e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    step(1'b0, 1'b1, 1'b0, rop(), rb(), e, "ld_fetch");
    e = '0; e.state = 3'd1;
    step(1'b0, 1'b0, 1'b0, 4'h8, rb(), e, "ld_decode");
    e = '0; e.state = 3'd2; e.alu_src_b = 1'b1;
    step(1'b0, 1'b0, 1'b0, rop(), rb(), e, "ld_exec");
    step(1'b1, rb(), 1'b1, rop(), rb(), '0, "rst_mid_mem");
    e = '0; e.imem_req = 1'b1;
    step(1'b0, 1'b0, 1'b0, rop(), rb(), e, "after_rst_mem");

    // Illegal opcode traps and stays trapped.
    run_instr(4'hF, 1'b0, 0, 0, cyc);
    for (int i = 0; i < 20; i++) begin
      e = '0; e.illegal = 1'b1; e.state = 3'd6;
      step(1'b0, rb(), rb(), rop(), rb(), e, "trap_hold");
    end
    do_reset(1);
    e = '0; e.imem_req = 1'b1;
    step(1'b0, 1'b0, 1'b0, rop(), rb(), e, "trap_cleared");

    // Opcode E also traps.
    run_instr(4'hE, 1'b0, 1, 0, cyc);
    e = '0; e.illegal = 1'b1; e.state = 3'd6;
    step(1'b0, 1'b1, 1'b1, rop(), rb(), e, "trap_e");
    do_reset(1);

    // HALT ignores stray acks.
    run_instr(4'hD, 1'b0, 0, 0, cyc);
    for (int i = 0; i < 12; i++) begin
      e = '0; e.halted = 1'b1; e.state = 3'd5;
      step(1'b0, 1'b1, 1'b1, rop(), rb(), e, "halt_hold");
    end
    do_reset(1);
    e = '0; e.imem_req = 1'b1;
    step(1'b0, 1'b0, 1'b0, rop(), rb(), e, "halt_cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm.md
# ctrl_fsm

Multi-cycle control unit that sequences one instruction at a time through fetch, decode, execute, memory and writeback. It drives the instruction-register, PC, ALU, register-file and data-memory control strobes around the instruction decoder. It consumes the 4-bit opcode field `instr[3:0]` produced by that decoder. It handshakes with instruction and data memory through req/ack pairs.

## Interface
Parameters:
- none; opcode map and state encodings below are fixed.

Ports:
- `clk_i` in 1: single clock, all state changes on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `opcode_i` in 4: decoded opcode field from the instruction register.
- `zero_i` in 1: ALU result-is-zero flag, combinational from the datapath.
- `imem_req_o` out 1: instruction fetch request.
- `imem_ack_i` in 1: instruction data valid this cycle.
- `dmem_req_o` out 1: data memory request.
- `dmem_we_o` out 1: 1 = store, 0 = load; valid while `dmem_req_o`=1.
- `dmem_ack_i` in 1: data access complete this cycle.
- `ir_we_o` out 1: load instruction register.
- `pc_we_o` out 1: write PC.
- `pc_src_o` out 2: PC source. 0 = PC+4, 1 = PC+sext(offset), 2 = sext(offset) absolute.
- `alu_op_o` out 3: ALU operation. 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT.
- `alu_src_b_o` out 1: ALU operand B. 0 = rb, 1 = sign-extended 11-bit offset.
- `rf_we_o` out 1: register file write of rd.
- `wb_sel_o` out 1: writeback source. 0 = ALU result, 1 = load data.
- `halted_o` out 1: sticky, core halted.
- `illegal_o` out 1: sticky, illegal opcode trapped.
- `state_o` out 3: current state, for debug.

## Operation
Opcode map:
- 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLT, 7 ADDI.
- 8 LD, 9 ST, A BEQ, B BNE, C JMP, D HALT.
- E and F are illegal.

State encodings on `state_o`: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.

States and transitions:
- FETCH:
  - `imem_req_o`=1.
  - On `imem_ack_i`: `ir_we_o`=1, `pc_we_o`=1, `pc_src_o`=0 (all Mealy, same cycle); go to DECODE. Otherwise stay.
- DECODE:
  - Latch `opcode_i` into an internal register. `opcode_i` is ignored in every other state.
  - E/F → TRAP; D → HALT; 0 → FETCH; all others → EXEC.
- EXEC:
  - ALU ops 1–6: `alu_op_o` per map, `alu_src_b_o`=0 → WB.
  - ADDI: ADD, `alu_src_b_o`=1 → WB.
  - LD/ST: ADD, `alu_src_b_o`=1 → MEM.
  - BEQ/BNE: SUB, `alu_src_b_o`=0, `pc_src_o`=1. `pc_we_o`=`zero_i` for BEQ, `!zero_i` for BNE → FETCH.
  - JMP: `pc_we_o`=1, `pc_src_o`=2 → FETCH.
- MEM:
  - `dmem_req_o`=1; `dmem_we_o`=1 for ST, 0 for LD.
  - `alu_op_o`=ADD and `alu_src_b_o`=1 are held.
  - On `dmem_ack_i`: ST → FETCH, LD → WB. Otherwise stay.
- WB:
  - `rf_we_o`=1 for exactly one cycle. `wb_sel_o`=1 for LD, else 0.
  - ALU controls are held from EXEC → FETCH.
- HALT:
  - `halted_o`=1. All strobes 0.
  - Terminal; only reset exits.
- TRAP:
  - `illegal_o`=1. All strobes 0.
  - Terminal; only reset exits.

Output defaults: any output not listed for a state is 0.

## Timing
- Reset: a rising edge with `rst_i`=1 sets state=FETCH and clears the latched opcode.
  - While `rst_i`=1, every output is forced to 0 combinationally, including `imem_req_o`.
  - After the reset edge: `state_o`=0 and `imem_req_o`=1.
- Reset mid-operation (any state, including a pending memory request) aborts the instruction. No strobe fires in the reset cycle.
- Ack gating:
  - `imem_ack_i` is ignored outside FETCH; `dmem_ack_i` is ignored outside MEM.
  - Req is held high until ack and deasserts on the cycle after ack.
- Latency with zero-wait memory (ack in the first req cycle), in cycles:
  - NOP: 2.
  - JMP, BEQ, BNE: 3.
  - ALU ops, ADDI, ST: 4.
  - LD: 5.
  - Each wait cycle adds 1.
- `pc_we_o` fires at most twice per instruction: once in FETCH, plus once in EXEC for a taken branch or JMP.
- `rf_we_o` fires at most once per instruction.
- `ir_we_o` fires exactly once per instruction.

## Test plan
- Reset then ADD with `imem_ack_i` high every cycle:
  - `state_o` sequence 0,1,2,4,0.
  - `rf_we_o`=1 only in the WB cycle, with `alu_op_o`=0 and `wb_sel_o`=0.
- LD with `dmem_ack_i` delayed 3 cycles:
  - MEM lasts 4 cycles with `dmem_req_o`=1 and `dmem_we_o`=0.
  - Then WB with `wb_sel_o`=1; total 8 cycles.
- BEQ with `zero_i`=1, then BNE with `zero_i`=1:
  - BEQ: `pc_we_o`=1 and `pc_src_o`=1 in EXEC.
  - BNE: `pc_we_o`=0 in EXEC.
  - Neither writes the register file.
- Opcode F:
  - TRAP after DECODE; `illegal_o`=1 held for 20 cycles with all strobes 0.
  - Assert `rst_i` → `state_o`=0 and `illegal_o`=0.
- Reset mid-fetch:
  - Assert `rst_i` while `imem_req_o`=1 and `imem_ack_i` pulses in the same cycle.
  - `ir_we_o`=0 that cycle; fetch restarts in the next cycle.
- HALT, with a stray `dmem_ack_i`/`imem_ack_i` injected while halted:
  - `halted_o` stays 1 and `state_o`=5.
  - No strobe toggles.
